// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter (MEM priority, ALU aging boost); optional RF_WB_ARB_STATS_EN conflict counter.
// Latency: grant to rf_we 1 cycle; backpressure: ready is combinational, one real write per cycle, x0 requests always accepted.
module rf_wb_arbiter #(
  parameter int REG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_wd,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_a3,
  output logic [DATA_W-1:0] rf_wd,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {MEM_PRI = 1'b0, ALU_BOOST = 1'b1} state_t;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mem_real, alu_real;
  logic       mem_gnt, alu_gnt;

  // x0 requests never touch the port, so only real requests compete
  assign mem_real = mem_valid && (mem_rd != '0);
  assign alu_real = alu_valid && (alu_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEM_PRI;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      MEM_PRI: begin
        if (alu_real && !alu_gnt) begin
          cnt_nxt = cnt + 4'd1;
          if (cnt == STARVE_LAST) state_nxt = ALU_BOOST;
        end else begin
          cnt_nxt = '0;
        end
      end
      ALU_BOOST: begin
        // boost lasts one cycle: either the ALU is served or it has gone away
        state_nxt = MEM_PRI;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = MEM_PRI;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    mem_gnt   = 1'b0;
    alu_gnt   = 1'b0;
    mem_ready = 1'b0;
    alu_ready = 1'b0;
    if (rst_n) begin
      case (state)
        MEM_PRI: begin
          mem_gnt = mem_real;
          alu_gnt = alu_real && !mem_real;
        end
        ALU_BOOST: begin
          // a vanished ALU request in boost forfeits the slot for everyone
          alu_gnt = alu_real;
          mem_gnt = mem_real && alu_valid && !alu_real;
        end
        default: begin
          mem_gnt = 1'b0;
          alu_gnt = 1'b0;
        end
      endcase
      mem_ready = (mem_valid && (mem_rd == '0)) || mem_gnt;
      alu_ready = (alu_valid && (alu_rd == '0)) || alu_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_a3 <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= mem_gnt || alu_gnt;
      if (mem_gnt) begin
        rf_a3 <= mem_rd;
        rf_wd <= mem_wd;
      end else if (alu_gnt) begin
        rf_a3 <= alu_rd;
        rf_wd <= alu_wd;
      end
    end
  end

`ifdef RF_WB_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
    end else if (mem_real && alu_real && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed vector table, hand-written corner sequences, random traffic vs. a reference model.
// Inputs driven 1 time unit after the rising edge, outputs sampled mid-cycle.
module tb_rf_wb_arbiter;
  localparam int REG_W      = 5;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
`ifdef RF_WB_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_valid, mem_ready, alu_valid, alu_ready, rf_we;
  logic [REG_W-1:0]  mem_rd, alu_rd, rf_a3;
  logic [DATA_W-1:0] mem_wd, alu_wd, rf_wd;
  logic [15:0]       conflict_cnt;

  rf_wb_arbiter #(.REG_W(REG_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_rd = '0; mem_wd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
  endtask

  // leaves the bench at posedge+1 with reset released
  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic              mv;
    logic [REG_W-1:0]  mrd;
    logic [DATA_W-1:0] mwd;
    logic              av;
    logic [REG_W-1:0]  ard;
    logic [DATA_W-1:0] awd;
    logic              emr;
    logic              ear;
    logic              ewe;
    logic [REG_W-1:0]  ea3;
    logic [DATA_W-1:0] ewd;
  } vec_t;

  vec_t vecs[14];

  // random-phase requester and model state
  logic              m_v, a_v;
  logic [REG_W-1:0]  m_rd, a_rd;
  logic [DATA_W-1:0] m_wd, a_wd;
  logic              e_we;
  logic [REG_W-1:0]  e_a3;
  logic [DATA_W-1:0] e_wd;
  int                waited;
  int                conf;

  initial begin
    //             mv  mrd    mwd           av  ard    awd           emr ear ewe ea3    ewd
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h1234_5678, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd3,  32'h1234_5678};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd3,  32'h1234_5678};
    vecs[3]  = '{1'b1, 5'd5,  32'hA,        1'b1, 5'd6,  32'hB,         1'b1, 1'b0, 1'b0, 5'd3,  32'h1234_5678};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'hB,         1'b0, 1'b1, 1'b1, 5'd5,  32'hA};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd6,  32'hB};
    vecs[6]  = '{1'b1, 5'd0,  32'h55,       1'b1, 5'd9,  32'h99,        1'b1, 1'b1, 1'b0, 5'd6,  32'hB};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd9,  32'h99};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd9,  32'h99};
    vecs[9]  = '{1'b1, 5'd10, 32'h1,        1'b1, 5'd10, 32'h2,         1'b1, 1'b0, 1'b0, 5'd9,  32'h99};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h2,         1'b0, 1'b1, 1'b1, 5'd10, 32'h1};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 5'd10, 32'h2};
    vecs[12] = '{1'b1, 5'd0,  32'h3,        1'b1, 5'd0,  32'h4,         1'b1, 1'b1, 1'b0, 5'd10, 32'h2};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 5'd10, 32'h2};

    // ---- reset state: readies forced low even with requests pending ----
    mem_valid = 1'b1; mem_rd = 5'd5; mem_wd = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_wd = 32'h2;
    #3;
    chk("rst mem_ready", mem_ready, 1'b0);
    chk("rst alu_ready", alu_ready, 1'b0);
    chk("rst rf_we", rf_we, 1'b0);
    chk("rst rf_a3", rf_a3, 0);
    chk("rst rf_wd", rf_wd, 0);
    chk("rst conflict_cnt", conflict_cnt, 0);
    do_reset();

    // ---- directed table ----
    for (int i = 0; i < 14; i++) begin
      mem_valid = vecs[i].mv; mem_rd = vecs[i].mrd; mem_wd = vecs[i].mwd;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_wd = vecs[i].awd;
      #4;
      chk($sformatf("vec%0d mem_ready", i), mem_ready, vecs[i].emr);
      chk($sformatf("vec%0d alu_ready", i), alu_ready, vecs[i].ear);
      chk($sformatf("vec%0d rf_we", i), rf_we, vecs[i].ewe);
      chk($sformatf("vec%0d rf_a3", i), rf_a3, vecs[i].ea3);
      chk($sformatf("vec%0d rf_wd", i), rf_wd, vecs[i].ewd);
      if (i == 4) chk("vec4 conflict_cnt", conflict_cnt, STATS ? 16'd1 : 16'd0);
      @(posedge clk); #1;
    end
    chk("table conflict_cnt", conflict_cnt, STATS ? 16'd2 : 16'd0);

    // ---- starvation boost: ALU served on the 5th cycle, then MEM priority again ----
    do_reset();
    for (int c = 0; c < 9; c++) begin
      mem_valid = 1'b1; mem_rd = 5'd7; mem_wd = 32'h700 + 32'(c);
      alu_valid = (c <= 4) || (c == 7); alu_rd = 5'd8; alu_wd = 32'h88;
      #4;
      chk($sformatf("starve c%0d alu_ready", c), alu_ready, c == 4);
      chk($sformatf("starve c%0d mem_ready", c), mem_ready, c != 4);
      if (c == 5) begin
        chk("starve c5 rf_a3", rf_a3, 5'd8);
        chk("starve c5 rf_wd", rf_wd, 32'h88);
      end
      if (c == 6) begin
        chk("starve c6 rf_a3", rf_a3, 5'd7);
        chk("starve c6 rf_wd", rf_wd, 32'h705);
      end
      if (c > 0) chk($sformatf("starve c%0d rf_we", c), rf_we, 1'b1);
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---- async reset before the granting edge ----
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_wd = 32'h1;
    #4;
    chk("arst1 alu_ready before", alu_ready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst1 alu_ready", alu_ready, 1'b0);
    chk("arst1 mem_ready", mem_ready, 1'b0);
    chk("arst1 rf_we", rf_we, 1'b0);
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("arst1 post c%0d rf_we", c), rf_we, 1'b0);
      @(posedge clk); #1;
    end

    // ---- async reset while the write is on the port ----
    alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
    @(posedge clk); #1;
    idle_inputs();
    chk("arst2 rf_we before", rf_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2 rf_we", rf_we, 1'b0);
    chk("arst2 rf_a3", rf_a3, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #4;
    chk("arst2 post rf_we", rf_we, 1'b0);

    // ---- random traffic against the reference model ----
    do_reset();
    m_v = 1'b0; a_v = 1'b0; m_rd = '0; a_rd = '0; m_wd = '0; a_wd = '0;
    e_we = 1'b0; e_a3 = '0; e_wd = '0;
    waited = 0; conf = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic mem_real, alu_real, boosted, emr, ear;
      if (!m_v) begin
        m_v  = ($urandom_range(0, 9) < 7);
        m_rd = 5'($urandom_range(0, 7));
        m_wd = $urandom;
      end
      if (!a_v) begin
        a_v  = ($urandom_range(0, 9) < 5);
        a_rd = 5'($urandom_range(0, 7));
        a_wd = $urandom;
      end
      mem_valid = m_v; mem_rd = m_rd; mem_wd = m_wd;
      alu_valid = a_v; alu_rd = a_rd; alu_wd = a_wd;
      #4;
      mem_real = m_v && (m_rd != 0);
      alu_real = a_v && (a_rd != 0);
      boosted  = (waited >= STARVE_MAX);
      ear = a_v && ((a_rd == 0) || boosted || !mem_real);
      emr = m_v && ((m_rd == 0) || !(boosted && (alu_real || !a_v)));
      chk("rand mem_ready", mem_ready, emr);
      chk("rand alu_ready", alu_ready, ear);
      chk("rand rf_we", rf_we, e_we);
      chk("rand rf_a3", rf_a3, e_a3);
      chk("rand rf_wd", rf_wd, e_wd);
      chk("rand conflict_cnt", conflict_cnt, STATS ? 16'((conf > 65535) ? 65535 : conf) : 16'd0);
      // next-cycle model state
      if (emr && mem_real) begin
        e_we = 1'b1; e_a3 = m_rd; e_wd = m_wd;
      end else if (ear && alu_real) begin
        e_we = 1'b1; e_a3 = a_rd; e_wd = a_wd;
      end else begin
        e_we = 1'b0;
      end
      if (boosted || !alu_real || ear) waited = 0;
      else waited = waited + 1;
      if (mem_real && alu_real) conf = conf + 1;
      if (emr) m_v = 1'b0;
      if (ear) a_v = 1'b0;
      @(posedge clk); #1;
    end
    idle_inputs();

`ifdef RF_WB_ARB_STATS_EN
    // ---- conflict counter saturation ----
    do_reset();
    mem_valid = 1'b1; mem_rd = 5'd1; mem_wd = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_wd = 32'h2;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat conflict_cnt", conflict_cnt, 16'hFFFF);
    repeat (10) @(posedge clk);
    #1;
    chk("sat hold conflict_cnt", conflict_cnt, 16'hFFFF);
    idle_inputs();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
